// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash target front end.
//   - command opcodes seen on the IO bus during CLE cycles
//   - FSM state encoding
//   - strobe_t: one sample of the flash interface pins
//   - page geometry
package nfc_pkg;

   localparam int PAGE_BYTES = 512;
   localparam int COL_W      = 9;

   localparam logic [7:0] CMD_READ0   = 8'h00;
   localparam logic [7:0] CMD_READ1   = 8'h01;
   localparam logic [7:0] CMD_PROG    = 8'h80;
   localparam logic [7:0] CMD_CONFIRM = 8'h10;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LOAD_BUSY,
      ST_READ_OUT,
      ST_PROG_DATA,
      ST_PROG_BUSY
   } state_t;

   typedef struct packed {
      logic       wen;
      logic       ren;
      logic       cle;
      logic       ale;
      logic [7:0] io;
   } strobe_t;

   // Bus at rest: both enables deasserted (high), no latch enables.
   localparam strobe_t STROBE_IDLE = '{wen: 1'b1, ren: 1'b1, cle: 1'b0, ale: 1'b0, io: 8'h00};

endpackage

// File: rtl/nand_flash_target_if.sv
// Backing-array bus between the flash target and its byte-wide storage.
//   mem_addr  : {row, column} byte address
//   mem_wdata : write data
//   mem_we    : write strobe
//   mem_rdata : read data, valid one clk after mem_addr
// master = flash target, slave = storage (SRAM macro or bench memory).
interface nand_flash_target_if #(
   parameter int ADDR_W = 18
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;

   modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
   modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/nand_strobe_sync.sv
// Two-flop synchronizer for the asynchronous flash pins, plus rising-edge
// detect on the second-stage WEN and REN.
//   clk, rst  : sampling clock, async active-high reset
//   raw       : pin values as seen on the package
//   sync      : second-stage values (the ones latched with an edge)
//   wen_rise  : one-clk pulse on a second-stage WEN rising edge
//   ren_rise  : one-clk pulse on a second-stage REN rising edge
module nand_strobe_sync
   import nfc_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  strobe_t raw,
   output strobe_t sync,
   output logic    wen_rise,
   output logic    ren_rise
);

   strobe_t s1;
   logic    wen_d, ren_d;

   // Enables reset high so leaving reset never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= STROBE_IDLE;
         sync  <= STROBE_IDLE;
         wen_d <= 1'b1;
         ren_d <= 1'b1;
      end else begin
         s1    <= raw;
         sync  <= s1;
         wen_d <= sync.wen;
         ren_d <= sync.ren;
      end
   end

   assign wen_rise = sync.wen & ~wen_d;
   assign ren_rise = sync.ren & ~ren_d;

endmodule

// File: rtl/nand_flash_target.sv
// Device-side NAND flash front end with a 512-byte page register.
//   clk, rst        : sampling clock (>= 4x strobe rate), async active-high reset
//   F_IO            : bidirectional command/address/data bus
//   F_CLE, F_ALE    : command / address latch enables
//   F_WEN           : write enable, latched on its (synchronized) rising edge
//   F_REN           : read enable, active low
//   F_RB            : ready(1) / busy(0)
//   mem             : backing-array master port (addr/wdata/we out, rdata in)
// Page loads and stores stream the whole page through the array while F_RB
// is low; strobes during busy are ignored. Address cycles assume ROW_W = 9.
module nand_flash_target
   import nfc_pkg::*;
#(
   parameter int ROW_W        = 9,
   parameter int T_R_EXTRA    = 16,
   parameter int T_PROG_EXTRA = 64
) (
   input  logic                clk,
   input  logic                rst,
   inout  wire  [7:0]          F_IO,
   input  logic                F_CLE,
   input  logic                F_ALE,
   input  logic                F_WEN,
   input  logic                F_REN,
   output logic                F_RB,
   nand_flash_target_if.master mem
);

   localparam int BCNT_W = 12;
   // Load: 512 address clks + 1 for the read latency + extra.
   localparam logic [BCNT_W-1:0] LOAD_LAST = BCNT_W'(PAGE_BYTES + T_R_EXTRA);
   localparam logic [BCNT_W-1:0] PROG_LAST = BCNT_W'(PAGE_BYTES + T_PROG_EXTRA - 1);
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PAGE_BYTES - 1);
   localparam logic [BCNT_W-1:0] PAGE_CNT  = BCNT_W'(PAGE_BYTES);

   strobe_t raw, s;
   logic    wen_rise, ren_rise;

   assign raw = '{wen: F_WEN, ren: F_REN, cle: F_CLE, ale: F_ALE, io: F_IO};

   nand_strobe_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw),
      .sync     (s),
      .wen_rise (wen_rise),
      .ren_rise (ren_rise)
   );

   state_t             state, state_n;
   logic [7:0]         page [PAGE_BYTES];
   logic [COL_W-1:0]   column;
   logic [ROW_W-1:0]   row, row_next;
   logic [1:0]         addr_cnt;
   logic               col_base, is_prog, col_full;
   logic [BCNT_W-1:0]  bcnt, bcnt_inc;
   logic [COL_W-1:0]   byte_nxt;
   logic               busy, cmd_ev, addr_ev, data_ev, load_wr, io_oe;

   assign busy     = (state == ST_LOAD_BUSY) || (state == ST_PROG_BUSY);
   assign cmd_ev   = wen_rise & s.cle & ~s.ale & ~busy;
   assign addr_ev  = wen_rise & s.ale & ~s.cle & (state == ST_ADDR);
   assign data_ev  = wen_rise & ~s.cle & ~s.ale & (state == ST_PROG_DATA);
   assign row_next = ROW_W'({s.io[0], row[7:0]});
   assign bcnt_inc = bcnt + 1'b1;
   assign byte_nxt = bcnt_inc[COL_W-1:0];
   // Read data for address k arrives while bcnt = k+1.
   assign load_wr  = (state == ST_LOAD_BUSY) && (bcnt != '0) && (bcnt <= PAGE_CNT);

   // Drive the bus only for a clean read strobe; never while the host may drive.
   assign io_oe = (state == ST_READ_OUT) && !s.ren && s.wen && !s.cle && !s.ale;
   assign F_IO  = io_oe ? page[column] : 8'hzz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_LOAD_BUSY: if (bcnt == LOAD_LAST) state_n = ST_READ_OUT;
         ST_PROG_BUSY: if (bcnt == PROG_LAST) state_n = ST_IDLE;
         default: begin
            if (cmd_ev) begin
               case (s.io)
                  CMD_READ0, CMD_READ1, CMD_PROG: state_n = ST_ADDR;
                  CMD_RESET:   state_n = ST_IDLE;
                  CMD_CONFIRM: if (state == ST_PROG_DATA) state_n = ST_PROG_BUSY;
                  default: ;
               endcase
            end else if (addr_ev && addr_cnt == 2'd2) begin
               state_n = is_prog ? ST_PROG_DATA : ST_LOAD_BUSY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         F_RB          <= 1'b1;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_we    <= 1'b0;
         column        <= '0;
         row           <= '0;
         addr_cnt      <= '0;
         col_base      <= 1'b0;
         is_prog       <= 1'b0;
         col_full      <= 1'b0;
         bcnt          <= '0;
      end else begin
         F_RB       <= !((state_n == ST_LOAD_BUSY) || (state_n == ST_PROG_BUSY));
         mem.mem_we <= 1'b0;

         if (cmd_ev) begin
            case (s.io)
               CMD_READ0: begin col_base <= 1'b0; is_prog <= 1'b0; addr_cnt <= '0; end
               CMD_READ1: begin col_base <= 1'b1; is_prog <= 1'b0; addr_cnt <= '0; end
               CMD_PROG: begin
                  col_base <= 1'b0;
                  is_prog  <= 1'b1;
                  addr_cnt <= '0;
                  col_full <= 1'b0;
               end
               CMD_CONFIRM: if (state == ST_PROG_DATA) begin
                  bcnt          <= '0;
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= {row, COL_W'(0)};
                  mem.mem_wdata <= page[0];
               end
               default: ;
            endcase
         end

         if (addr_ev) begin
            addr_cnt <= addr_cnt + 1'b1;
            case (addr_cnt)
               2'd0:    column   <= {col_base, s.io};
               2'd1:    row[7:0] <= s.io;
               default: begin
                  row          <= row_next;
                  bcnt         <= '0;
                  mem.mem_addr <= {row_next, COL_W'(0)};
               end
            endcase
         end

         // Column saturates after the last byte; later data is dropped.
         if (data_ev && !col_full) begin
            if (column == COL_W'(PAGE_BYTES - 1)) col_full <= 1'b1;
            else                                  column   <= column + 1'b1;
         end

         case (state)
            ST_LOAD_BUSY: begin
               bcnt         <= bcnt_inc;
               mem.mem_addr <= {row, byte_nxt};
            end
            ST_READ_OUT: if (ren_rise) column <= column + 1'b1;
            ST_PROG_BUSY: begin
               bcnt <= bcnt_inc;
               if (bcnt < LAST_BYTE) begin
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= {row, byte_nxt};
                  mem.mem_wdata <= page[byte_nxt];
               end
            end
            default: ;
         endcase
      end
   end

   // Page register: no reset, contents are defined by the command flow.
   always_ff @(posedge clk) begin
      if (cmd_ev && s.io == CMD_PROG) begin
         for (int i = 0; i < PAGE_BYTES; i++) page[i] <= 8'hFF;
      end else if (load_wr) begin
         page[bcnt[COL_W-1:0] - 1'b1] <= mem.mem_rdata;
      end else if (data_ev && !col_full) begin
         page[column] <= s.io;
      end
   end

endmodule

// File: tb/tb_nand_flash_target.sv
// Directed bench for nand_flash_target: bench-side byte array as backing
// storage, host strobes driven at 1/8 of clk, expected values hand-derived.
module tb_nand_flash_target;
   import nfc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wire  [7:0] F_IO;
   logic       F_CLE = 1'b0, F_ALE = 1'b0, F_WEN = 1'b1, F_REN = 1'b1;
   wire        F_RB;
   logic       tb_oe = 1'b0;
   logic [7:0] tb_io = 8'h00;

   assign F_IO = tb_oe ? tb_io : 8'hzz;
   // Released bus reads back as 0xFF.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (F_IO[g]);
   end

   nand_flash_target_if mif ();

   nand_flash_target dut (
      .clk   (clk),
      .rst   (rst),
      .F_IO  (F_IO),
      .F_CLE (F_CLE),
      .F_ALE (F_ALE),
      .F_WEN (F_WEN),
      .F_REN (F_REN),
      .F_RB  (F_RB),
      .mem   (mif)
   );

   logic [7:0] mem [0:262143];
   always @(posedge clk) begin
      if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
      mif.mem_rdata <= mem[mif.mem_addr];
   end

   // Running monitors; tests use differences of snapshots.
   int         low_cnt = 0, we_cnt = 0, we_bad = 0, we_idx = 0;
   logic       we_prev = 1'b0;
   logic [8:0] we_row  = 9'd0;
   always @(negedge clk) begin
      if (!F_RB) low_cnt <= low_cnt + 1;
      we_prev <= mif.mem_we;
      if (mif.mem_we) begin
         we_cnt <= we_cnt + 1;
         we_idx <= (we_prev ? we_idx : 0) + 1;
         if (mif.mem_addr !== {we_row, 9'(we_prev ? we_idx : 0)}) we_bad <= we_bad + 1;
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic wen_cycle(input logic cle, input logic ale, input logic [7:0] d);
      @(negedge clk);
      F_CLE = cle; F_ALE = ale; tb_io = d; tb_oe = 1'b1; F_WEN = 1'b0;
      repeat (4) @(negedge clk);
      F_WEN = 1'b1;
      repeat (4) @(negedge clk);
      F_CLE = 1'b0; F_ALE = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] d);
      @(negedge clk);
      F_REN = 1'b0;
      repeat (4) @(negedge clk);
      d = F_IO;
      F_REN = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_ready(input int bound, output bit timed_out);
      int n = 0;
      timed_out = 1'b0;
      while (F_RB !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > bound) begin timed_out = 1'b1; break; end
      end
   endtask

   task automatic issue_addr(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
      wen_cycle(1'b0, 1'b1, a0);
      wen_cycle(1'b0, 1'b1, a1);
      wen_cycle(1'b0, 1'b1, a2);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (F_RB !== 1'b1) begin n_fail++; $display("FAIL reset_rb: got %b want 1", F_RB); end
      n_tests++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mif.mem_we); end
      n_tests++; if (mif.mem_addr !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mif.mem_addr); end
      n_tests++; if (mif.mem_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mif.mem_wdata); end
      n_tests++; if (F_IO !== 8'hFF) begin n_fail++; $display("FAIL reset_io: got %h want released(ff)", F_IO); end
   endtask

   task automatic test_read_page;
      int base, errs;
      bit to;
      logic [7:0] d;
      wen_cycle(1'b1, 1'b0, CMD_READ0);
      base = low_cnt;
      issue_addr(8'h00, 8'h05, 8'h00);
      wait_ready(2000, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL read_timeout: busy did not end"); end
      n_tests++; if (low_cnt - base != 529) begin n_fail++; $display("FAIL read_busy_len: got %0d want 529", low_cnt - base); end
      n_tests++; if (F_IO !== 8'hFF) begin n_fail++; $display("FAIL read_idle_release: got %h want ff", F_IO); end
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         read_byte(d);
         if (d !== (8'(i) ^ 8'hA5)) begin
            if (errs == 0) $display("FAIL read_data[%0d]: got %h want %h", i, d, 8'(i) ^ 8'hA5);
            errs++;
         end
      end
      n_tests++; if (errs != 0) begin n_fail++; $display("FAIL read_data_errs: got %0d want 0", errs); end
      read_byte(d);
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL read_wrap: got %h want a5", d); end
      // Read strobe with CLE high must not turn the bus around.
      @(negedge clk); F_CLE = 1'b1; F_REN = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++; if (F_IO !== 8'hFF) begin n_fail++; $display("FAIL read_cle_release: got %h want ff", F_IO); end
      F_REN = 1'b1; F_CLE = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_odd_half;
      int base;
      bit to;
      logic [7:0] d;
      wen_cycle(1'b1, 1'b0, CMD_READ1);
      base = low_cnt;
      issue_addr(8'h10, 8'h05, 8'h00);
      wait_ready(2000, to);
      n_tests++; if (to || low_cnt - base != 529) begin n_fail++; $display("FAIL odd_busy_len: got %0d want 529", low_cnt - base); end
      read_byte(d);
      n_tests++; if (d !== 8'hB5) begin n_fail++; $display("FAIL odd_first: got %h want b5", d); end
      read_byte(d);
      n_tests++; if (d !== 8'hB4) begin n_fail++; $display("FAIL odd_second: got %h want b4", d); end
   endtask

   task automatic test_program;
      int lbase, wbase, bbase, errs, bl;
      bit to;
      logic [7:0] d;
      we_row = 9'd263;
      wen_cycle(1'b1, 1'b0, CMD_PROG);
      issue_addr(8'h00, 8'h07, 8'h01);
      for (int i = 0; i < 512; i++) wen_cycle(1'b0, 1'b0, 8'(i));
      lbase = low_cnt; wbase = we_cnt; bbase = we_bad;
      wen_cycle(1'b1, 1'b0, CMD_CONFIRM);
      wait_ready(2000, to);
      bl = low_cnt - lbase;
      n_tests++; if (to) begin n_fail++; $display("FAIL prog_timeout: busy did not end"); end
      n_tests++; if (bl < 576 || bl > 600) begin n_fail++; $display("FAIL prog_busy_len: got %0d want 576..600", bl); end
      n_tests++; if (we_cnt - wbase != 512) begin n_fail++; $display("FAIL prog_we_cnt: got %0d want 512", we_cnt - wbase); end
      n_tests++; if (we_bad != bbase) begin n_fail++; $display("FAIL prog_we_addr: got %0d bad want 0", we_bad - bbase); end
      errs = 0;
      for (int i = 0; i < 512; i++) if (mem[{9'd263, 9'(i)}] !== 8'(i)) errs++;
      n_tests++; if (errs != 0) begin n_fail++; $display("FAIL prog_array: got %0d bad bytes want 0", errs); end
      wen_cycle(1'b1, 1'b0, CMD_READ0);
      issue_addr(8'h00, 8'h07, 8'h01);
      wait_ready(2000, to);
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         read_byte(d);
         if (d !== 8'(i)) errs++;
      end
      n_tests++; if (to || errs != 0) begin n_fail++; $display("FAIL prog_readback: got %0d bad bytes want 0", errs); end
   endtask

   task automatic test_partial;
      int errs;
      bit to;
      logic [7:0] exp;
      wen_cycle(1'b1, 1'b0, CMD_PROG);
      issue_addr(8'h00, 8'h03, 8'h00);
      wen_cycle(1'b0, 1'b0, 8'h11);
      wen_cycle(1'b0, 1'b0, 8'h22);
      wen_cycle(1'b0, 1'b0, 8'h33);
      wen_cycle(1'b0, 1'b0, 8'h44);
      we_row = 9'd3;
      wen_cycle(1'b1, 1'b0, CMD_CONFIRM);
      wait_ready(2000, to);
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         case (i)
            0: exp = 8'h11;
            1: exp = 8'h22;
            2: exp = 8'h33;
            3: exp = 8'h44;
            default: exp = 8'hFF;
         endcase
         if (mem[{9'd3, 9'(i)}] !== exp) errs++;
      end
      n_tests++; if (to || errs != 0) begin n_fail++; $display("FAIL partial_array: got %0d bad bytes want 0", errs); end
      n_tests++; if (mem[{9'd3, 9'd4}] !== 8'hFF) begin n_fail++; $display("FAIL partial_fill: got %h want ff", mem[{9'd3, 9'd4}]); end
   endtask

   task automatic test_illegal_overflow_busy;
      int lbase, wbase, errs, bl;
      bit to;
      lbase = low_cnt; wbase = we_cnt;
      wen_cycle(1'b1, 1'b0, CMD_CONFIRM);
      wen_cycle(1'b1, 1'b0, 8'h55);
      repeat (20) @(negedge clk);
      n_tests++; if (F_RB !== 1'b1 || low_cnt != lbase) begin n_fail++; $display("FAIL idle_confirm_rb: got %0d busy clks want 0", low_cnt - lbase); end
      n_tests++; if (we_cnt != wbase) begin n_fail++; $display("FAIL idle_confirm_we: got %0d writes want 0", we_cnt - wbase); end
      we_row = 9'd8;
      wen_cycle(1'b1, 1'b0, CMD_PROG);
      issue_addr(8'h00, 8'h08, 8'h00);
      for (int i = 0; i < 600; i++) wen_cycle(1'b0, 1'b0, (i < 512) ? 8'(i) : 8'hC3);
      lbase = low_cnt; wbase = we_cnt;
      wen_cycle(1'b1, 1'b0, CMD_CONFIRM);
      // All of these land while busy and must be ignored.
      wen_cycle(1'b1, 1'b0, CMD_RESET);
      wen_cycle(1'b1, 1'b0, CMD_READ0);
      issue_addr(8'h00, 8'h05, 8'h00);
      wait_ready(2000, to);
      bl = low_cnt - lbase;
      n_tests++; if (to || bl < 576 || bl > 600) begin n_fail++; $display("FAIL busy_ignore_len: got %0d want 576..600", bl); end
      n_tests++; if (we_cnt - wbase != 512) begin n_fail++; $display("FAIL overflow_we_cnt: got %0d want 512", we_cnt - wbase); end
      errs = 0;
      for (int i = 0; i < 512; i++) if (mem[{9'd8, 9'(i)}] !== 8'(i)) errs++;
      n_tests++; if (errs != 0) begin n_fail++; $display("FAIL overflow_array: got %0d bad bytes want 0", errs); end
      lbase = low_cnt;
      repeat (20) @(negedge clk);
      n_tests++; if (low_cnt != lbase) begin n_fail++; $display("FAIL busy_addr_ignored: got %0d busy clks want 0", low_cnt - lbase); end
   endtask

   task automatic test_reset_mid;
      int lbase, n;
      bit to;
      logic [7:0] d;
      we_row = 9'd9;
      wen_cycle(1'b1, 1'b0, CMD_PROG);
      issue_addr(8'h00, 8'h09, 8'h00);
      wen_cycle(1'b0, 1'b0, 8'h5A);
      lbase = low_cnt;
      wen_cycle(1'b1, 1'b0, CMD_CONFIRM);
      n = 0;
      while (low_cnt - lbase < 100 && n < 1000) begin @(negedge clk); n++; end
      n_tests++; if (n >= 1000) begin n_fail++; $display("FAIL midrst_timeout: busy never reached 100 clks"); end
      n_tests++; if (mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %b want 1", mif.mem_we); end
      rst = 1'b1;
      #1;
      n_tests++; if (F_RB !== 1'b1) begin n_fail++; $display("FAIL midrst_rb: got %b want 1", F_RB); end
      n_tests++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b want 0", mif.mem_we); end
      n_tests++; if (F_IO !== 8'hFF) begin n_fail++; $display("FAIL midrst_io: got %h want released(ff)", F_IO); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      wen_cycle(1'b1, 1'b0, CMD_READ0);
      lbase = low_cnt;
      issue_addr(8'h00, 8'h05, 8'h00);
      wait_ready(2000, to);
      n_tests++; if (to || low_cnt - lbase != 529) begin n_fail++; $display("FAIL postrst_busy_len: got %0d want 529", low_cnt - lbase); end
      read_byte(d);
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL postrst_read: got %h want a5", d); end
      read_byte(d);
      n_tests++; if (d !== 8'hA4) begin n_fail++; $display("FAIL postrst_read1: got %h want a4", d); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[{9'd5, 9'(i)}]   = 8'(i) ^ 8'hA5;
         mem[{9'd3, 9'(i)}]   = 8'h00;
         mem[{9'd8, 9'(i)}]   = 8'h00;
         mem[{9'd263, 9'(i)}] = 8'h00;
      end
      test_reset;
      test_read_page;
      test_odd_half;
      test_program;
      test_partial;
      test_illegal_overflow_busy;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
